// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- ID/EX pipeline register feeding the combinational ALU.
//
// Holds one decoded instruction and presents alu_op / operand A / operand B
// until the execute/memory stage accepts it. Operand sources are register,
// PC or immediate. Register values may be bypassed from MEM/WB.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   : MEM/WB bypass when the instruction is captured, and snoop
//               updates of the stored rs values while the instruction stalls.
//   undefined : forwarding inputs are ignored; rs values come only from
//               the decode read data. The port list is the same.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_flush                  kill held and incoming instruction
//   i_dec_* / o_dec_ready    decode-side valid/ready handshake and fields
//   i_mem_fwd_*, i_wb_fwd_*  MEM/WB destination, write enable and result
//   o_ex_valid / i_ex_ready  execute-side handshake
//   o_alu_op, o_operand_a/b  to the ALU
//   o_ex_rd_addr, o_ex_rd_we held destination

package riscv_defines;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;
endpackage

module alu_issue_stage
  import riscv_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_dec_valid,
  output logic                  o_dec_ready,
  input  alu_op_t               i_dec_alu_op,
  input  logic [REG_ADDR_W-1:0] i_dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_dec_rs2_addr,
  input  logic [DATA_WIDTH-1:0] i_dec_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_dec_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_dec_pc,
  input  logic [DATA_WIDTH-1:0] i_dec_imm,
  input  logic                  i_dec_use_pc,
  input  logic                  i_dec_use_imm,
  input  logic [REG_ADDR_W-1:0] i_dec_rd_addr,
  input  logic                  i_dec_rd_we,
  input  logic                  i_mem_fwd_we,
  input  logic                  i_wb_fwd_we,
  input  logic [REG_ADDR_W-1:0] i_mem_fwd_rd,
  input  logic [REG_ADDR_W-1:0] i_wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_fwd_data,
  input  logic [DATA_WIDTH-1:0] i_wb_fwd_data,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output alu_op_t               o_alu_op,
  output logic [DATA_WIDTH-1:0] o_operand_a,
  output logic [DATA_WIDTH-1:0] o_operand_b,
  output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
  output logic                  o_ex_rd_we
);

  typedef struct packed {
    alu_op_t               op;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic                  use_pc;
    logic                  use_imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
  } entry_t;

  logic   valid_q, valid_d;
  entry_t entry_q, entry_d;
  logic   capture;

`ifdef ALU_ISSUE_FWD_EN
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;

  // MEM beats WB; x0 is never bypassed. With no match the caller's fallback
  // is kept: regfile data at capture, the stored value while snooping.
  function automatic logic [DATA_WIDTH-1:0] bypass(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_WIDTH-1:0] fallback
  );
    if (rs == '0)                             return fallback;
    else if (i_mem_fwd_we && i_mem_fwd_rd == rs) return i_mem_fwd_data;
    else if (i_wb_fwd_we && i_wb_fwd_rd == rs)   return i_wb_fwd_data;
    else                                      return fallback;
  endfunction
`else
  logic fwd_unused;
  assign fwd_unused = ^{i_mem_fwd_we, i_wb_fwd_we, i_mem_fwd_rd, i_wb_fwd_rd,
                        i_mem_fwd_data, i_wb_fwd_data,
                        i_dec_rs1_addr, i_dec_rs2_addr};
`endif

  assign o_dec_ready = !valid_q || i_ex_ready;
  assign capture     = i_dec_valid && o_dec_ready;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
`ifdef ALU_ISSUE_FWD_EN
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
`endif
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d         = 1'b1;
      entry_d.op      = i_dec_alu_op;
      entry_d.pc      = i_dec_pc;
      entry_d.imm     = i_dec_imm;
      entry_d.use_pc  = i_dec_use_pc;
      entry_d.use_imm = i_dec_use_imm;
      entry_d.rd      = i_dec_rd_addr;
      entry_d.rd_we   = i_dec_rd_we;
`ifdef ALU_ISSUE_FWD_EN
      rs1_d           = i_dec_rs1_addr;
      rs2_d           = i_dec_rs2_addr;
      entry_d.rs1_val = bypass(i_dec_rs1_addr, i_dec_rs1_data);
      entry_d.rs2_val = bypass(i_dec_rs2_addr, i_dec_rs2_data);
`else
      entry_d.rs1_val = i_dec_rs1_data;
      entry_d.rs2_val = i_dec_rs2_data;
`endif
    end else if (valid_q && i_ex_ready) begin
      valid_d = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    end else if (valid_q) begin
      // Stalled: pick up results retiring underneath the held instruction.
      entry_d.rs1_val = bypass(rs1_q, entry_q.rs1_val);
      entry_d.rs2_val = bypass(rs2_q, entry_q.rs2_val);
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      entry_q    <= '0;
      entry_q.op <= ALU_NOP;
`ifdef ALU_ISSUE_FWD_EN
      rs1_q      <= '0;
      rs2_q      <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      entry_q    <= entry_d;
`ifdef ALU_ISSUE_FWD_EN
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
`endif
    end
  end

  // Operands keep their last values when idle; op and write enable are
  // squashed so a bubble can never write the register file.
  assign o_ex_valid   = valid_q;
  assign o_alu_op     = valid_q ? entry_q.op : ALU_NOP;
  assign o_ex_rd_we   = valid_q && entry_q.rd_we;
  assign o_ex_rd_addr = entry_q.rd;
  assign o_operand_a  = entry_q.use_pc  ? entry_q.pc  : entry_q.rs1_val;
  assign o_operand_b  = entry_q.use_imm ? entry_q.imm : entry_q.rs2_val;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import riscv_defines::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          dec_valid = 1'b0;
  logic          dec_ready;
  alu_op_t       dec_op = ALU_NOP;
  logic [AW-1:0] rs1a = '0, rs2a = '0, rda = '0;
  logic [DW-1:0] rs1d = '0, rs2d = '0, pc = '0, imm = '0;
  logic          use_pc = 1'b0, use_imm = 1'b0, rdwe = 1'b0;
  logic          mem_we = 1'b0, wb_we = 1'b0;
  logic [AW-1:0] mem_rd = '0, wb_rd = '0;
  logic [DW-1:0] mem_d = '0, wb_d = '0;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  alu_op_t       alu_op;
  logic [DW-1:0] opa, opb;
  logic [AW-1:0] ex_rd;
  logic          ex_we;

  int checks = 0;
  int failures = 0;

  alu_issue_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_alu_op(dec_op),
    .i_dec_rs1_addr(rs1a), .i_dec_rs2_addr(rs2a),
    .i_dec_rs1_data(rs1d), .i_dec_rs2_data(rs2d),
    .i_dec_pc(pc), .i_dec_imm(imm), .i_dec_use_pc(use_pc), .i_dec_use_imm(use_imm),
    .i_dec_rd_addr(rda), .i_dec_rd_we(rdwe),
    .i_mem_fwd_we(mem_we), .i_wb_fwd_we(wb_we),
    .i_mem_fwd_rd(mem_rd), .i_wb_fwd_rd(wb_rd),
    .i_mem_fwd_data(mem_d), .i_wb_fwd_data(wb_d),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_alu_op(alu_op), .o_operand_a(opa), .o_operand_b(opb),
    .o_ex_rd_addr(ex_rd), .o_ex_rd_we(ex_we)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    alu_op_t       op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] v1, v2, pc, imm;
    logic          upc, uimm, we;
  } ins_t;

  logic m_valid = 1'b0;
  ins_t m_ins = '{op: ALU_NOP, rs1: '0, rs2: '0, rd: '0, v1: '0, v2: '0,
                  pc: '0, imm: '0, upc: 1'b0, uimm: 1'b0, we: 1'b0};

  // Value a source register should see right now, given a fallback value.
  function automatic logic [DW-1:0] fwd_val(input logic [AW-1:0] r, input logic [DW-1:0] fb);
`ifdef ALU_ISSUE_FWD_EN
    if (r != 0 && mem_we && mem_rd == r) return mem_d;
    if (r != 0 && wb_we && wb_rd == r)   return wb_d;
`endif
    return fb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ins   <= '{op: ALU_NOP, rs1: '0, rs2: '0, rd: '0, v1: '0, v2: '0,
                   pc: '0, imm: '0, upc: 1'b0, uimm: 1'b0, we: 1'b0};
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (dec_valid && (!m_valid || ex_ready)) begin
      m_valid <= 1'b1;
      m_ins   <= '{op: dec_op, rs1: rs1a, rs2: rs2a, rd: rda,
                   v1: fwd_val(rs1a, rs1d), v2: fwd_val(rs2a, rs2d),
                   pc: pc, imm: imm, upc: use_pc, uimm: use_imm, we: rdwe};
    end else if (m_valid && ex_ready) begin
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m_ins.v1 <= fwd_val(m_ins.rs1, m_ins.v1);
      m_ins.v2 <= fwd_val(m_ins.rs2, m_ins.v2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("dec_ready", 64'(dec_ready), 64'(!m_valid || ex_ready));
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("alu_op", 64'(alu_op), 64'(m_valid ? m_ins.op : ALU_NOP));
    chk("operand_a", 64'(opa), 64'(m_ins.upc ? m_ins.pc : m_ins.v1));
    chk("operand_b", 64'(opb), 64'(m_ins.uimm ? m_ins.imm : m_ins.v2));
    chk("ex_rd_addr", 64'(ex_rd), 64'(m_ins.rd));
    chk("ex_rd_we", 64'(ex_we), 64'(m_valid && m_ins.we));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input alu_op_t op, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic [AW-1:0] rd, input logic we);
    dec_valid = 1'b1; dec_op = op;
    rs1a = a1; rs1d = d1; rs2a = a2; rs2d = d2; rda = rd; rdwe = we;
    use_pc = 1'b0; use_imm = 1'b0; pc = '0; imm = '0;
  endtask

  task automatic clr_fwd();
    mem_we = 1'b0; wb_we = 1'b0; mem_rd = '0; wb_rd = '0; mem_d = '0; wb_d = '0;
  endtask

  logic [DW-1:0] exp_a;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_op", 64'(alu_op), 64'(ALU_NOP));
    chk("rst_opa", 64'(opa), 64'd0);
    chk("rst_opb", 64'(opb), 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);
    chk("rst_we", 64'(ex_we), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic capture and accept
    ex_ready = 1'b1;
    offer(ALU_ADD, 5'd1, 32'h5, 5'd2, 32'h7, 5'd3, 1'b1);
    tick();
    dec_valid = 1'b0;
    chk("add_valid", 64'(ex_valid), 64'd1);
    chk("add_op", 64'(alu_op), 64'(ALU_ADD));
    chk("add_a", 64'(opa), 64'h5);
    chk("add_b", 64'(opb), 64'h7);
    chk("add_rd", 64'(ex_rd), 64'd3);
    chk("add_we", 64'(ex_we), 64'd1);
    tick();
    chk("acc_valid", 64'(ex_valid), 64'd0);
    chk("acc_op", 64'(alu_op), 64'(ALU_NOP));
    chk("acc_we", 64'(ex_we), 64'd0);
    chk("idle_a_kept", 64'(opa), 64'h5);

    // Stall for 3 cycles with next instruction pending, then no-bubble handoff
    ex_ready = 1'b0;
    offer(ALU_SUB, 5'd4, 32'h10, 5'd5, 32'h20, 5'd6, 1'b1);
    tick();
    offer(ALU_XOR, 5'd7, 32'h30, 5'd8, 32'h40, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 64'(dec_ready), 64'd0);
      chk("stall_op", 64'(alu_op), 64'(ALU_SUB));
      chk("stall_a", 64'(opa), 64'h10);
      chk("stall_rd", 64'(ex_rd), 64'd6);
      tick();
    end
    ex_ready = 1'b1;
    #1 chk("release_ready", 64'(dec_ready), 64'd1);
    tick();
    dec_valid = 1'b0;
    chk("handoff_valid", 64'(ex_valid), 64'd1);
    chk("handoff_op", 64'(alu_op), 64'(ALU_XOR));
    chk("handoff_a", 64'(opa), 64'h30);
    chk("handoff_b", 64'(opb), 64'h40);
    tick();

    // Capture-time bypass: MEM wins over WB
    offer(ALU_ADD, 5'd2, 32'h1, 5'd3, 32'h2, 5'd1, 1'b1);
    mem_we = 1'b1; mem_rd = 5'd2; mem_d = 32'hAAAA;
    wb_we = 1'b1; wb_rd = 5'd2; wb_d = 32'hBBBB;
`ifdef ALU_ISSUE_FWD_EN
    exp_a = 32'hAAAA;
`else
    exp_a = 32'h1;
`endif
    tick();
    chk("byp_mem_a", 64'(opa), 64'(exp_a));
    chk("byp_b_nomatch", 64'(opb), 64'h2);
    // x0 is never bypassed
    offer(ALU_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 1'b1);
    mem_rd = 5'd0; mem_d = 32'h1234; wb_rd = 5'd0;
    tick();
    chk("byp_x0_a", 64'(opa), 64'h0);
    chk("byp_x0_b", 64'(opb), 64'h0);
    dec_valid = 1'b0;
    clr_fwd();
    tick();

    // Snoop while held
    ex_ready = 1'b0;
    offer(ALU_OR, 5'd1, 32'h11, 5'd9, 32'h9, 5'd4, 1'b1);
    tick();
    dec_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd9; wb_d = 32'hCAFE;
    tick();
    clr_fwd();
`ifdef ALU_ISSUE_FWD_EN
    exp_a = 32'hCAFE;
`else
    exp_a = 32'h9;
`endif
    chk("snoop_b", 64'(opb), 64'(exp_a));
    chk("snoop_op", 64'(alu_op), 64'(ALU_OR));
    chk("snoop_a", 64'(opa), 64'h11);
    tick();
    chk("snoop_b_hold", 64'(opb), 64'(exp_a));
    ex_ready = 1'b1;
    tick();

    // Flush coincident with a decode handshake drops it
    offer(ALU_SLT, 5'd1, 32'h77, 5'd2, 32'h88, 5'd5, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dec_valid = 1'b0;
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_op", 64'(alu_op), 64'(ALU_NOP));

    // PC / immediate operand selects
    offer(ALU_ADD, 5'd1, 32'h55, 5'd2, 32'h66, 5'd10, 1'b1);
    use_pc = 1'b1; pc = 32'h100; use_imm = 1'b1; imm = 32'hFFFFF000;
    tick();
    dec_valid = 1'b0;
    chk("sel_a_pc", 64'(opa), 64'h100);
    chk("sel_b_imm", 64'(opb), 64'hFFFFF000);
    tick();

    // Async reset mid-stall
    ex_ready = 1'b0;
    offer(ALU_SRA, 5'd3, 32'h123, 5'd4, 32'h456, 5'd7, 1'b1);
    tick();
    dec_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(ex_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ex_valid), 64'd0);
    chk("async_rst_op", 64'(alu_op), 64'(ALU_NOP));
    chk("async_rst_we", 64'(ex_we), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Mixed traffic: every cycle compared against the model
    for (int i = 0; i < 60; i++) begin
      dec_valid = 1'($urandom_range(0, 1));
      ex_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      dec_op    = alu_op_t'($urandom_range(1, 11));
      rs1a = 5'($urandom_range(0, 3)); rs2a = 5'($urandom_range(0, 3));
      rs1d = $urandom; rs2d = $urandom; pc = $urandom; imm = $urandom;
      use_pc = 1'($urandom_range(0, 1)); use_imm = 1'($urandom_range(0, 1));
      rda = 5'($urandom); rdwe = 1'($urandom_range(0, 1));
      mem_we = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 3)); mem_d = $urandom;
      wb_we  = 1'($urandom_range(0, 1)); wb_rd  = 5'($urandom_range(0, 3)); wb_d  = $urandom;
      tick();
    end
    dec_valid = 1'b0; flush = 1'b0; clr_fwd();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register for the ALU; this is the producer end of the ALU operand interface.
- Accepts decoded instructions from decode over a valid/ready handshake.
- Resolves operand sources: register, PC or immediate, with MEM/WB bypass.
- Holds `alu_op`, operand A and operand B stable toward the combinational ALU until the execute/memory stage accepts the instruction.

Parameters:
- `DATA_WIDTH`, 32, operand/data width.
- `REG_ADDR_W`, 5, register index width.

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  async active-low reset
- `i_flush`  in  1  kill held and incoming instruction (branch/trap redirect)
- `i_dec_valid`  in  1  decode has an instruction
- `o_dec_ready`  out  1  stage can accept
- `i_dec_alu_op`  in  `alu_op_t`  ALU operation (`riscv_defines`)
- `i_dec_rs1_addr`, `i_dec_rs2_addr`  in  `REG_ADDR_W`  source indices
- `i_dec_rs1_data`, `i_dec_rs2_data`  in  `DATA_WIDTH`  regfile read data
- `i_dec_pc`  in  `DATA_WIDTH`  instruction PC
- `i_dec_imm`  in  `DATA_WIDTH`  sign-extended immediate
- `i_dec_use_pc`  in  1  operand A = PC (`auipc`, `jal`)
- `i_dec_use_imm`  in  1  operand B = immediate
- `i_dec_rd_addr`  in  `REG_ADDR_W`  destination
- `i_dec_rd_we`  in  1  destination write enable
- `i_mem_fwd_we`, `i_wb_fwd_we`  in  1  MEM/WB stage will write rd
- `i_mem_fwd_rd`, `i_wb_fwd_rd`  in  `REG_ADDR_W`  MEM/WB destination
- `i_mem_fwd_data`, `i_wb_fwd_data`  in  `DATA_WIDTH`  MEM/WB result
- `o_ex_valid`  out  1  held instruction valid
- `i_ex_ready`  in  1  downstream accepts
- `o_alu_op`  out  `alu_op_t`  to ALU `i_alu_op`
- `o_operand_a`, `o_operand_b`  out  `DATA_WIDTH`  to ALU operands
- `o_ex_rd_addr`  out  `REG_ADDR_W`  held destination
- `o_ex_rd_we`  out  1  held destination write enable

Behaviour:
- Reset (async, `i_rst_n`=0):
  - `valid_q`=0.
  - All stored fields 0; stored op = `ALU_NOP`.
  - Outputs: `o_ex_valid`=0, `o_alu_op`=`ALU_NOP`, operands 0, `o_ex_rd_addr`=0, `o_ex_rd_we`=0.
  - Reset mid-hold discards the instruction.
- Single-entry register.
  - `o_dec_ready` = `!valid_q || i_ex_ready` (combinational; no dependency on `i_dec_valid`).
  - Capture on `i_dec_valid && o_dec_ready`.
- Next-state priority per clock edge:
  1. `i_flush`: `valid_q`←0. Any same-cycle decode handshake is dropped.
  2. Capture: `valid_q`←1; all fields loaded.
  3. `i_ex_ready && valid_q`: `valid_q`←0.
  4. Otherwise hold.
- Latency: one cycle, decode handshake → `o_ex_valid`. Back-to-back throughput is 1/cycle when `i_ex_ready`=1.
- Bypass at capture, applied to rs1 and rs2 independently:
  - Index 0 is never bypassed; x0 stays as supplied by decode.
  - MEM match (`i_mem_fwd_we` && `i_mem_fwd_rd`==rs) wins over WB match; otherwise use regfile data.
- Snoop while held (`valid_q`=1, not accepted, not flushed):
  - Each cycle the same bypass rule overwrites stored rs1/rs2 values.
  - A result retiring while the instruction stalls is therefore not lost.
- Output muxing is combinational from stored state:
  - `o_operand_a` = `use_pc` ? `pc` : `rs1_val`.
  - `o_operand_b` = `use_imm` ? `imm` : `rs2_val`.
  - When `valid_q`=0: `o_alu_op`=`ALU_NOP` and `o_ex_rd_we`=0; operands keep their last values.
- Held outputs change only through snoop updates. `o_alu_op`, `o_ex_rd_addr` and the select flags never change while `o_ex_valid`=1 && `!i_ex_ready`.
- No load-use detection; decode is responsible for stalling load-use hazards.

Optional Feature:
- Macro `ALU_ISSUE_FWD_EN`.
- Defined: capture-time bypass and hold-time snoop as specified above.
- Undefined:
  - Forwarding inputs are ignored, and rs values come only from `i_dec_rs*_data`.
  - No snoop.
  - Port list is unchanged.
  - Decode must stall on all RAW hazards.

Test Plan:
- Reset, then capture `ALU_ADD`, rs1=0x5, rs2=0x7, rd=3 → next cycle `o_ex_valid`=1, `o_operand_a`=5, `o_operand_b`=7; accepted with `i_ex_ready`=1 → `o_ex_valid`=0, `o_alu_op`=`ALU_NOP`.
- `i_ex_ready`=0 for 3 cycles while decode offers the next instruction → `o_dec_ready`=0, outputs stable; release → the next instruction is captured the same edge the held one leaves (no bubble).
- rs1=2 at capture with MEM rd=2 data=0xAAAA and WB rd=2 data=0xBBBB → `o_operand_a`=0xAAAA; rs1=0 with MEM rd=0 data=0x1234 → `o_operand_a`=decode value 0.
- Held instruction rs2=9, stall; WB rd=9 data=0xCAFE arrives → `o_operand_b`=0xCAFE next cycle, `o_alu_op` unchanged; with `ALU_ISSUE_FWD_EN` undefined → `o_operand_b` unchanged.
- `i_flush`=1 coincident with decode handshake → next cycle `o_ex_valid`=0, `o_alu_op`=`ALU_NOP`; `use_pc`=1, pc=0x100, `use_imm`=1, imm=0xFFFFF000 → operands 0x100 / 0xFFFFF000.
- Assert `i_rst_n`=0 asynchronously mid-stall → `o_ex_valid`=0 and `o_alu_op`=`ALU_NOP` before the next clock edge.
